ram_fill_engine: RTL and testbench

- Parametrised successor to the single-bank RAM clear logic.
- Writes a programmable address window of a single-port block RAM with a constant or incrementing pattern, one word per clock.
- Uses a start/busy/done handshake and supports abort on bank switch.
- Sits between the NAND page-buffer RAM mux and the controller FSM. It clears or preloads page buffers before program/read transfers.

---
 rtl/ram_fill_pkg.sv | 19 +
 rtl/ram_fill_patgen.sv | 19 +
 rtl/ram_fill_engine.sv | 206 ++++++++++++++++++++
 tb/tb_ram_fill_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fill_pkg.sv
// ram_fill_pkg: shared types and defaults for the RAM fill engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_fill_pkg;

    localparam int RF_ADDR_W = 15;
    localparam int RF_DATA_W = 8;
    localparam int RF_DEPTH  = 16384;

    localparam logic MODE_CONST = 1'b0;
    localparam logic MODE_INCR  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        VERIFY = 2'd2
    } state_t;

endpackage

// File: rtl/ram_fill_patgen.sv
// ram_fill_patgen: pattern word for index idx_i, either the seed or seed+idx (mod 2^DATA_W).
// Latency: combinational.
// Backpressure: none.
module ram_fill_patgen
    import ram_fill_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int IDX_W  = RF_ADDR_W + 1
) (
    input  logic [DATA_W-1:0] seed_i,
    input  logic              mode_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [DATA_W-1:0] word_o
);

    // Only the low DATA_W bits of the index matter because the sum wraps.
    assign word_o = (mode_i == MODE_INCR) ? (seed_i + DATA_W'(idx_i)) : seed_i;

endmodule

// File: rtl/ram_fill_engine.sv
// ram_fill_engine: writes a constant/incrementing pattern over an address window of a single-port RAM.
// Latency: start-to-done len+1 cycles, one word per clock; 2*len+2 with read-back (macro RAM_FILL_VERIFY_EN).
// Backpressure: none; start is sampled only in IDLE and never queued, abort cancels in any state.
module ram_fill_engine
    import ram_fill_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              mode,
    input  logic [DATA_W-1:0] fill_data,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              verify_err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam int               LEN_W   = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    state_t              state_q;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                mode_q;
    logic [DATA_W-1:0]   seed_q;
    logic                ram_en_q, ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_wdata_q;
    logic                busy_q, done_q, aborted_q;
    logic [DATA_W-1:0]   wr_pat;

    // Clamp the requested word count and form the next word index.
    always_comb begin
        len_d = (len > DEPTH_L) ? DEPTH_L : len;
        cnt_d = cnt_q + LEN_W'(1);
    end

    // Write data for the word after the one currently on the RAM port.
    ram_fill_patgen #(.DATA_W(DATA_W), .IDX_W(LEN_W)) u_wr_pat (
        .seed_i (seed_q),
        .mode_i (mode_q),
        .idx_i  (cnt_d),
        .word_o (wr_pat)
    );

`ifdef RAM_FILL_VERIFY_EN
    logic [ADDR_W-1:0] base_q, cmp_addr_q, err_addr_q;
    logic [DATA_W-1:0] exp_q, rd_pat;
    logic              cmp_vld_q, verify_err_q;

    // Expected data for the read being issued this cycle.
    ram_fill_patgen #(.DATA_W(DATA_W), .IDX_W(LEN_W)) u_rd_pat (
        .seed_i (seed_q),
        .mode_i (mode_q),
        .idx_i  (cnt_q),
        .word_o (rd_pat)
    );
`else
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;
`endif

    // Control FSM; every RAM-port and status output comes straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
            seed_q      <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
`ifdef RAM_FILL_VERIFY_EN
            base_q       <= '0;
            cmp_addr_q   <= '0;
            err_addr_q   <= '0;
            exp_q        <= '0;
            cmp_vld_q    <= 1'b0;
            verify_err_q <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
`ifdef RAM_FILL_VERIFY_EN
            cmp_vld_q <= 1'b0;
`endif
            if (abort) begin
                // Abort beats everything, including a start in the same cycle.
                state_q   <= IDLE;
                cnt_q     <= '0;
                ram_en_q  <= 1'b0;
                ram_we_q  <= 1'b0;
                busy_q    <= 1'b0;
                aborted_q <= 1'b1;
            end else begin
`ifdef RAM_FILL_VERIFY_EN
                // Read data arrives one cycle after its address; only the first miss is kept.
                if (cmp_vld_q && (ram_rdata != exp_q) && !verify_err_q) begin
                    verify_err_q <= 1'b1;
                    err_addr_q   <= cmp_addr_q;
                end
`endif
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            mode_q <= mode;
                            seed_q <= fill_data;
                            len_q  <= len_d;
                            cnt_q  <= '0;
`ifdef RAM_FILL_VERIFY_EN
                            base_q       <= base_addr;
                            verify_err_q <= 1'b0;
                            err_addr_q   <= '0;
`endif
                            if (len_d == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q     <= FILL;
                                busy_q      <= 1'b1;
                                ram_en_q    <= 1'b1;
                                ram_we_q    <= 1'b1;
                                ram_addr_q  <= base_addr;
                                ram_wdata_q <= fill_data;
                            end
                        end
                    end
                    FILL: begin
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            cnt_q    <= '0;
                            ram_we_q <= 1'b0;
`ifdef RAM_FILL_VERIFY_EN
                            state_q    <= VERIFY;
                            ram_addr_q <= base_q;
`else
                            state_q  <= IDLE;
                            ram_en_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
`endif
                        end else begin
                            cnt_q       <= cnt_d;
                            ram_addr_q  <= ram_addr_q + ADDR_W'(1);
                            ram_wdata_q <= wr_pat;
                        end
                    end
`ifdef RAM_FILL_VERIFY_EN
                    VERIFY: begin
                        if (ram_en_q) begin
                            cmp_vld_q  <= 1'b1;
                            cmp_addr_q <= ram_addr_q;
                            exp_q      <= rd_pat;
                            if (cnt_q == len_q - LEN_W'(1)) begin
                                cnt_q    <= '0;
                                ram_en_q <= 1'b0;
                            end else begin
                                cnt_q      <= cnt_d;
                                ram_addr_q <= ram_addr_q + ADDR_W'(1);
                            end
                        end else begin
                            // Drain cycle: the final compare lands on this edge.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
`ifdef RAM_FILL_VERIFY_EN
    assign verify_err = verify_err_q;
    assign err_addr   = err_addr_q;
`else
    assign verify_err = 1'b0;
    assign err_addr   = '0;
`endif

endmodule

// File: tb/tb_ram_fill_engine.sv
// tb_ram_fill_engine: drives fill operations and checks RAM traffic and handshakes against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_fill_engine;

    localparam int AW  = 15;
    localparam int LW  = AW + 1;
    localparam int DW  = 8;
    localparam int DEP = 16384;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len = '0;
    logic [DW-1:0] fill_data = '0;
    logic [DW-1:0] ram_rdata = '0;
    logic          ram_en, ram_we, busy, done, aborted, verify_err;
    logic [AW-1:0] ram_addr, err_addr;
    logic [DW-1:0] ram_wdata;

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    typedef struct {
        int n_wr; int bad_wr; int n_rd; int busy_cnt;
        int n_done; int done_cyc; int n_abort; int abort_cyc; int both;
        logic busy_at_done; logic verr; logic [AW-1:0] eaddr;
    } res_t;

    always #5 clk = ~clk;

    ram_fill_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .len(len), .mode(mode), .fill_data(fill_data),
        .ram_rdata(ram_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .busy(busy), .done(done), .aborted(aborted),
        .verify_err(verify_err), .err_addr(err_addr)
    );

    // Single-port RAM with 1-cycle read latency; can flip one bit on a chosen read address.
    always @(posedge clk) begin
        if (ram_en === 1'b1) begin
            if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
            else ram_rdata <= mem[ram_addr] ^ ((corrupt_en && ram_addr == corrupt_addr) ? 8'h01 : 8'h00);
        end
    end

    // Reference model: i-th word of a window, straight from the address/data rules.
    function automatic int exp_addr(int b, int i);
        return (b + i) % (1 << AW);
    endfunction
    function automatic int exp_data(int m, int f, int i);
        return (m != 0) ? (f + i) % (1 << DW) : f;
    endfunction
    function automatic int clamp(int l);
        return (l > DEP) ? DEP : l;
    endfunction
    function automatic int lat(int n);
`ifdef RAM_FILL_VERIFY_EN
        return (n == 0) ? 1 : 2 * n + 2;
`else
        return n + 1;
`endif
    endfunction
    function automatic int busy_cycles(int n);
`ifdef RAM_FILL_VERIFY_EN
        return (n == 0) ? 0 : 2 * n + 1;
`else
        return n;
`endif
    endfunction

    // Issue one operation and record what the DUT did, cycle 0 being the start cycle.
    task automatic run_op(input int b, input int l, input int m, input int f,
                          input int abort_at, input int start2_at, output res_t r);
        int eff, limit, last;
        eff   = clamp(l);
        limit = 2 * eff + 12;
        last  = limit;
        r = '{default: 0};
        r.done_cyc  = -1;
        r.abort_cyc = -1;
        @(negedge clk);
        base_addr = AW'(b);
        len       = LW'(l);
        mode      = (m != 0);
        fill_data = DW'(f);
        start     = 1'b1;
        abort     = (abort_at == 0);
        for (int k = 1; k <= limit && k <= last; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            base_addr = AW'(b);
            if (ram_en === 1'b1 && ram_we === 1'b1) begin
                if (ram_addr !== AW'(exp_addr(b, r.n_wr)) || ram_wdata !== DW'(exp_data(m, f, r.n_wr)))
                    r.bad_wr++;
                r.n_wr++;
                if (abort_at > 0 && r.n_wr == abort_at) abort = 1'b1;
            end
            if (ram_en === 1'b1 && ram_we === 1'b0) r.n_rd++;
            if (busy === 1'b1) r.busy_cnt++;
            if (done === 1'b1) begin
                r.n_done++;
                if (r.done_cyc < 0) begin r.done_cyc = k; r.busy_at_done = busy; last = k + 3; end
            end
            if (aborted === 1'b1) begin
                r.n_abort++;
                if (r.abort_cyc < 0) begin r.abort_cyc = k; last = k + 3; end
            end
            if (done === 1'b1 && aborted === 1'b1) r.both++;
            if (k == start2_at) begin start = 1'b1; base_addr = AW'(b + 77); end
        end
        r.verr  = verify_err;
        r.eaddr = err_addr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if ({ram_en, ram_we, busy, done, aborted, verify_err} !== 6'b0) begin
            mismatched++; $display("FAIL reset_ctrl: got %b want 000000", {ram_en, ram_we, busy, done, aborted, verify_err});
        end
        compared++;
        if ({ram_addr, ram_wdata, err_addr} !== '0) begin
            mismatched++; $display("FAIL reset_buses: got %h/%h/%h want 0", ram_addr, ram_wdata, err_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_clear();
        res_t r;
        run_op(0, DEP, 0, 0, -1, -1, r);
        compared++; if (r.n_wr !== DEP) begin mismatched++; $display("FAIL clear_writes: got %0d want %0d", r.n_wr, DEP); end
        compared++; if (r.bad_wr !== 0) begin mismatched++; $display("FAIL clear_data: got %0d bad want 0", r.bad_wr); end
        compared++; if (r.done_cyc !== lat(DEP)) begin mismatched++; $display("FAIL clear_latency: got %0d want %0d", r.done_cyc, lat(DEP)); end
        compared++; if (r.busy_at_done !== 1'b0) begin mismatched++; $display("FAIL clear_busy_at_done: got %b want 0", r.busy_at_done); end
        compared++; if (r.busy_cnt !== busy_cycles(DEP)) begin mismatched++; $display("FAIL clear_busy_cycles: got %0d want %0d", r.busy_cnt, busy_cycles(DEP)); end
    endtask

    task automatic test_wrap_incr();
        res_t r;
        logic [AW-1:0] a;
        run_op(32'h7FFE, 4, 1, 8'hFE, -1, -1, r);
        compared++; if (r.n_wr !== 4 || r.bad_wr !== 0) begin mismatched++; $display("FAIL wrap_writes: got %0d (%0d bad) want 4 (0 bad)", r.n_wr, r.bad_wr); end
        compared++; if (r.done_cyc !== lat(4)) begin mismatched++; $display("FAIL wrap_latency: got %0d want %0d", r.done_cyc, lat(4)); end
        a = 15'h7FFF;
        compared++; if (mem[a] !== 8'hFF) begin mismatched++; $display("FAIL wrap_mem_7fff: got %h want ff", mem[a]); end
        a = 15'h0001;
        compared++; if (mem[a] !== 8'h01) begin mismatched++; $display("FAIL wrap_mem_0001: got %h want 01", mem[a]); end
        compared++; if (r.n_done !== 1 || r.n_abort !== 0) begin mismatched++; $display("FAIL wrap_pulses: got done=%0d aborted=%0d want 1/0", r.n_done, r.n_abort); end
    endtask

    task automatic test_zero_len();
        res_t r;
        run_op(int'($urandom_range(0, 32767)), 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), -1, -1, r);
        compared++; if (r.n_wr + r.n_rd !== 0) begin mismatched++; $display("FAIL zero_ram_access: got %0d want 0", r.n_wr + r.n_rd); end
        compared++; if (r.done_cyc !== 1 || r.n_done !== 1) begin mismatched++; $display("FAIL zero_done: got cyc %0d cnt %0d want 1/1", r.done_cyc, r.n_done); end
        compared++; if (r.busy_cnt !== 0) begin mismatched++; $display("FAIL zero_busy: got %0d want 0", r.busy_cnt); end
    endtask

    task automatic test_abort();
        res_t r;
        logic got_ab, got_dn;
        run_op(int'($urandom_range(0, 32767)), 100, int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 10, -1, r);
        compared++; if (r.n_wr !== 10 || r.bad_wr !== 0 || r.n_rd !== 0) begin mismatched++; $display("FAIL abort_writes: got %0d (%0d bad, %0d rd) want 10", r.n_wr, r.bad_wr, r.n_rd); end
        compared++; if (r.abort_cyc !== 11 || r.n_abort !== 1) begin mismatched++; $display("FAIL abort_pulse: got cyc %0d cnt %0d want 11/1", r.abort_cyc, r.n_abort); end
        compared++; if (r.n_done !== 0 || r.both !== 0) begin mismatched++; $display("FAIL abort_no_done: got %0d want 0", r.n_done); end
        run_op(int'($urandom_range(0, 32767)), 50, 0, 8'h5A, 0, -1, r);
        compared++; if (r.n_wr !== 0 || r.busy_cnt !== 0) begin mismatched++; $display("FAIL start_abort_writes: got %0d wr %0d busy want 0/0", r.n_wr, r.busy_cnt); end
        compared++; if (r.abort_cyc !== 1 || r.n_abort !== 1 || r.n_done !== 0) begin mismatched++; $display("FAIL start_abort_pulse: got cyc %0d ab %0d dn %0d want 1/1/0", r.abort_cyc, r.n_abort, r.n_done); end
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0; got_ab = aborted; got_dn = done;
        compared++; if (got_ab !== 1'b1 || got_dn !== 1'b0) begin mismatched++; $display("FAIL idle_abort: got aborted=%b done=%b want 1/0", got_ab, got_dn); end
    endtask

    task automatic test_back_to_back();
        res_t r;
        int b;
        b = int'($urandom_range(0, 32767));
        run_op(b, 20, 1, int'($urandom_range(0, 255)), -1, 5, r);
        compared++; if (r.n_wr !== 20 || r.bad_wr !== 0) begin mismatched++; $display("FAIL busy_start_writes: got %0d (%0d bad) want 20", r.n_wr, r.bad_wr); end
        compared++; if (r.done_cyc !== lat(20) || r.n_done !== 1) begin mismatched++; $display("FAIL busy_start_done: got cyc %0d cnt %0d want %0d/1", r.done_cyc, r.n_done, lat(20)); end
        run_op(int'($urandom_range(0, 32767)), 20000, 0, int'($urandom_range(0, 255)), -1, -1, r);
        compared++; if (r.n_wr !== DEP || r.bad_wr !== 0) begin mismatched++; $display("FAIL oversize_writes: got %0d (%0d bad) want %0d", r.n_wr, r.bad_wr, DEP); end
        compared++; if (r.done_cyc !== lat(DEP)) begin mismatched++; $display("FAIL oversize_latency: got %0d want %0d", r.done_cyc, lat(DEP)); end
    endtask

    task automatic test_random();
        res_t r;
        int b, l, m, f;
        for (int n = 0; n < 8; n++) begin
            b = (n % 2 == 0) ? int'($urandom_range(32740, 32767)) : int'($urandom_range(0, 32767));
            l = int'($urandom_range(1, 40));
            m = int'($urandom_range(0, 1));
            f = int'($urandom_range(0, 255));
            run_op(b, l, m, f, -1, -1, r);
            compared++;
            if (r.n_wr !== l || r.bad_wr !== 0 || r.done_cyc !== lat(l) || r.both !== 0) begin
                mismatched++;
                $display("FAIL random_%0d: got wr %0d bad %0d done@%0d want wr %0d bad 0 done@%0d", n, r.n_wr, r.bad_wr, r.done_cyc, l, lat(l));
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int ev;
        @(negedge clk);
        base_addr = 15'h0100; len = LW'(50); mode = 1'b1; fill_data = 8'h10; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        compared++;
        if ({ram_en, ram_we, busy, done, aborted} !== 5'b0 || ram_addr !== '0) begin
            mismatched++; $display("FAIL midop_reset: got %b addr %h want 00000 addr 0", {ram_en, ram_we, busy, done, aborted}, ram_addr);
        end
        @(negedge clk); rst_n = 1'b1;
        ev = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ram_en !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || busy !== 1'b0) ev++;
        end
        compared++; if (ev !== 0) begin mismatched++; $display("FAIL midop_quiet: got %0d active cycles want 0", ev); end
    endtask

    task automatic test_verify();
        res_t r;
        corrupt_en = 1'b1; corrupt_addr = 15'h0005;
        run_op(0, 16, 1, 8'h30, -1, -1, r);
`ifdef RAM_FILL_VERIFY_EN
        compared++; if (r.verr !== 1'b1 || r.eaddr !== 15'h0005) begin mismatched++; $display("FAIL verify_detect: got err=%b addr=%h want 1/0005", r.verr, r.eaddr); end
        compared++; if (r.done_cyc !== 34 || r.n_rd !== 16) begin mismatched++; $display("FAIL verify_latency: got done@%0d rd %0d want 34/16", r.done_cyc, r.n_rd); end
        corrupt_en = 1'b0;
        run_op(0, 16, 1, 8'h30, -1, -1, r);
        compared++; if (r.verr !== 1'b0 || r.eaddr !== '0) begin mismatched++; $display("FAIL verify_clean: got err=%b addr=%h want 0/0000", r.verr, r.eaddr); end
`else
        compared++; if (r.verr !== 1'b0 || r.n_rd !== 0) begin mismatched++; $display("FAIL verify_off: got err=%b rd %0d want 0/0", r.verr, r.n_rd); end
        corrupt_en = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_full_clear();
        test_wrap_incr();
        test_zero_len();
        test_abort();
        test_back_to_back();
        test_random();
        test_verify();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
